// File: rtl/z_core_div_ctrl.sv
// Sequencing controller for the RV32M divide/remainder path: resolves divide-by-zero and signed overflow locally and drives z_core_div_unit otherwise.
// Optional one-entry result cache is built when Z_CORE_DIV_CACHE_EN is defined.
module z_core_div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  output logic             div_is_signed,
  output logic             div_quotient_or_rem,
  input  logic             div_done,
  input  logic             div_running,
  input  logic [31:0]      div_result,
  output logic [1:0]       dbg_state
);

  // Handshakes: a request transfers in a cycle with req_valid & req_ready; a response
  // transfers in a cycle with rsp_valid & rsp_ready & ~flush. Valid never drops without a transfer or a flush.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             b_zero;
  logic             sgn_ovf;
  logic             special;
  logic [31:0]      fast_res;
  logic             cache_hit;
  logic [31:0]      cache_res_w;
  logic             done_seen;
  logic             ld_fast;
  logic             ld_div;
  logic             ld_res;
  logic [TAG_W-1:0] tag_q;

  assign req_ready = (state == S_IDLE) & ~flush;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;
  assign accept    = req_valid & req_ready;

  // RISC-V defined results that need no iteration.
  assign b_zero   = (req_b == 32'h0);
  assign sgn_ovf  = ~req_op[0] & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);
  assign special  = b_zero | sgn_ovf;

  always_comb begin
    fast_res = 32'h0;
    if (b_zero) begin
      fast_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
    end else begin
      fast_res = req_op[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // A done pulse coinciding with our own start pulse cannot belong to this operation.
  assign done_seen = div_done & ~div_start;

`ifdef Z_CORE_DIV_CACHE_EN
  logic        cache_vld;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [1:0]  cache_op;
  logic [31:0] cache_res;
  logic        from_div;

  assign cache_hit   = cache_vld & (req_a == cache_a) & (req_b == cache_b) & (req_op == cache_op);
  assign cache_res_w = cache_res;

  // Only a divider result that was actually handed to the consumer is remembered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cache_vld <= 1'b0;
      cache_a   <= 32'h0;
      cache_b   <= 32'h0;
      cache_op  <= 2'b00;
      cache_res <= 32'h0;
    end else if ((state == S_RESP) && rsp_ready && !flush && from_div) begin
      cache_vld <= 1'b1;
      cache_a   <= div_dividend;
      cache_b   <= div_divisor;
      cache_op  <= {~div_quotient_or_rem, ~div_is_signed};
      cache_res <= rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      from_div <= 1'b0;
    end else if (ld_fast) begin
      from_div <= 1'b0;
    end else if (ld_res) begin
      from_div <= 1'b1;
    end
  end
`else
  assign cache_hit   = 1'b0;
  assign cache_res_w = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_fast   = 1'b0;
    ld_div    = 1'b0;
    ld_res    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (special || cache_hit) begin
            ld_fast   = 1'b1;
            state_nxt = S_RESP;
          end else begin
            ld_div    = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A flush landing on the done cycle has nothing left to drain.
        if (flush) begin
          state_nxt = done_seen ? S_IDLE : S_DRAIN;
        end else if (done_seen) begin
          ld_res    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (done_seen) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_start           <= 1'b0;
      div_dividend        <= 32'h0;
      div_divisor         <= 32'h0;
      div_is_signed       <= 1'b0;
      div_quotient_or_rem <= 1'b0;
      tag_q               <= '0;
      rsp_data            <= 32'h0;
      rsp_tag             <= '0;
    end else begin
      div_start <= ld_div;
      if (ld_div) begin
        div_dividend        <= req_a;
        div_divisor         <= req_b;
        div_is_signed       <= ~req_op[0];
        div_quotient_or_rem <= ~req_op[1];
        tag_q               <= req_tag;
      end
      if (ld_fast) begin
        rsp_data <= special ? fast_res : cache_res_w;
        rsp_tag  <= req_tag;
      end else if (ld_res) begin
        rsp_data <= div_result;
        rsp_tag  <= tag_q;
      end
    end
  end

  a_done_unexpected: assert property (@(posedge clk) disable iff (!rstn)
    div_done |-> (state == S_WAIT || state == S_DRAIN));

  a_start_while_running: assert property (@(posedge clk) disable iff (!rstn)
    div_start |-> !div_running);

endmodule

// File: tb/tb_z_core_div_ctrl.sv
// Bench for z_core_div_ctrl: behavioural divider, arithmetic reference model and scoreboard.
// Mirrors the Z_CORE_DIV_CACHE_EN build option in its latency prediction.
module tb_z_core_div_ctrl;

  localparam int TAG_W = 5;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic             clk;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             div_start;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_is_signed;
  logic             div_quotient_or_rem;
  logic             div_done;
  logic             div_running;
  logic [31:0]      div_result;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] tag_q[$];

  logic        c_vld = 1'b0;
  logic [31:0] c_a, c_b;
  logic [1:0]  c_op;

  z_core_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_is_signed(div_is_signed), .div_quotient_or_rem(div_quotient_or_rem),
    .div_done(div_done), .div_running(div_running), .div_result(div_result),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // RISC-V M-extension divide semantics
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) begin
      if (op[1]) return sa % sb;
      return sa / sb;
    end
    if (op[1]) return a % b;
    return a / b;
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural divider: start seen in cycle S, done pulse in cycle S+69.
  initial begin
    logic [31:0] d_a, d_b;
    logic [1:0]  d_op;
    div_done = 1'b0;
    div_running = 1'b0;
    div_result = 32'h0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && div_start === 1'b1) begin
        d_a  = div_dividend;
        d_b  = div_divisor;
        d_op = {~div_quotient_or_rem, ~div_is_signed};
        @(posedge clk);
        #1 div_running = 1'b1;
        repeat (68) @(posedge clk);
        #1;
        div_done = 1'b1;
        div_result = ref_result(d_op, d_a, d_b);
        @(posedge clk);
        #1;
        div_done = 1'b0;
        div_running = 1'b0;
        div_result = 32'h0;
      end
    end
  end

  task automatic wait_accept(output int t_acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("accept_timeout", {31'h0, req_ready}, 32'h1);
    t_acc = cyc;
  endtask

  // Driver + scoreboard for one request with rsp_ready held high.
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    int t_acc, lat, starts;
    logic div_path;
    logic [31:0] e;
    logic [TAG_W-1:0] et;
    exp_q.push_back(ref_result(op, a, b));
    tag_q.push_back(tag);
    div_path = !is_special(op, a, b);
`ifdef Z_CORE_DIV_CACHE_EN
    if (div_path && c_vld && c_a == a && c_b == b && c_op == op) div_path = 1'b0;
`endif
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
    wait_accept(t_acc);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("start_t1", {31'h0, div_start}, {31'h0, div_path});
    if (div_path) begin
      check("opnd_a", div_dividend, a);
      check("opnd_b", div_divisor, b);
      check("opnd_flags", {30'h0, div_is_signed, div_quotient_or_rem}, {30'h0, ~op[0], ~op[1]});
    end
    starts = div_start ? 1 : 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (div_start) starts++;
    end
    e  = exp_q.pop_front();
    et = tag_q.pop_front();
    check("latency", lat, div_path ? 71 : 1);
    check("starts", starts, div_path ? 1 : 0);
    check("rsp_data", rsp_data, e);
    check("rsp_tag", {27'h0, rsp_tag}, {27'h0, et});
    if (div_path) begin
      c_vld = 1'b1;
      c_a = a;
      c_b = b;
      c_op = op;
    end
    @(posedge clk);
    #1;
  endtask

  // DIV 100/7 flushed in cycle T+d; the divider must be drained.
  task automatic run_flush(input int d);
    int t_acc, k, bad;
    req_valid = 1'b1;
    req_op = OP_DIV;
    req_a = 32'd100;
    req_b = 32'd7;
    req_tag = 5'd1;
    wait_accept(t_acc);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (d - 1) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bad = 0;
    k = 0;
    @(negedge clk);
    while (!div_done && k < 200) begin
      if (!busy || rsp_valid || req_ready) bad++;
      @(negedge clk);
      k++;
    end
    check("flush_done_cycle", cyc - t_acc, 70);
    check("flush_hold", bad, 0);
    check("flush_ready_at_done", {31'h0, req_ready}, 32'h0);
    check("flush_no_rsp_at_done", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("flush_ready_after", {31'h0, req_ready}, 32'h1);
    check("flush_rsp_after", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_tag", {27'h0, rsp_tag}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_div_start", {31'h0, div_start}, 32'h0);
    check("rst_dividend", div_dividend, 32'h0);
    check("rst_divisor", div_divisor, 32'h0);
    check("rst_flags", {30'h0, div_is_signed, div_quotient_or_rem}, 32'h0);
  endtask

  initial begin
    int t_acc, bad;
    logic [1:0]  op, p_op;
    logic [31:0] a, b, p_a, p_b;
    int sel;
    rstn = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_a = 32'h0;
    req_b = 32'h0;
    req_tag = '0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rstn = 1'b1;

    // directed cases
    run_req(OP_DIV, 32'd100, 32'd7, 5'd3);
    run_req(OP_REM, 32'd100, 32'd7, 5'd4);
    run_req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_req(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_req(OP_DIVU, 32'd5, 32'd0, 5'd8);
    run_req(OP_REM, 32'd5, 32'd0, 5'd9);
    run_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_req(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_req(OP_DIV, 32'd100, 32'd7, 5'd13);
    run_req(OP_DIV, 32'd100, 32'd7, 5'd14);

    // flush while the divider runs, and on the start cycle
    run_flush(10);
    run_req(OP_DIVU, 32'd9, 32'd3, 5'd2);
    run_flush(1);
    run_req(OP_DIVU, 32'd9, 32'd3, 5'd15);

    // back-pressure hold, then release
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = OP_REM;
    req_a = 32'd5;
    req_b = 32'd0;
    req_tag = 5'd7;
    wait_accept(t_acc);
    @(posedge clk);
    #1;
    req_op = OP_DIVU;
    req_a = 32'd9;
    req_b = 32'd3;
    req_tag = 5'd2;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd5 || rsp_tag !== 5'd7 || req_ready !== 1'b0) bad++;
    end
    check("hold_stable", bad, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_data", rsp_data, 32'd5);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("hold_released", {31'h0, rsp_valid}, 32'h0);
    check("hold_idle_ready", {31'h0, req_ready}, 32'h1);

    // flush beats a simultaneous rsp_ready during a hold
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = OP_REM;
    req_a = 32'd5;
    req_b = 32'd0;
    req_tag = 5'd8;
    wait_accept(t_acc);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("flush_resp_pending", {31'h0, rsp_valid}, 32'h1);
    check("flush_blocks_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_resp_dropped", {31'h0, rsp_valid}, 32'h0);
    check("flush_resp_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;

    // randomized traffic
    p_op = OP_DIV;
    p_a = 32'd100;
    p_b = 32'd7;
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 7);
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 4);
        4: begin op = p_op; a = p_a; b = p_b; end
        default: ;
      endcase
      run_req(op, a, b, 5'($urandom_range(0, 31)));
      p_op = op;
      p_a = a;
      p_b = b;
    end

    // reset clears everything, including the cached entry
    rstn = 1'b0;
    c_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rstn = 1'b1;
    run_req(OP_DIV, 32'd100, 32'd7, 5'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
